fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Downstream drain stage for `synchronous_fifo`. It issues read strobes into the FIFO, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents the words on a valid/ready stream. It groups words into fixed-length packets with a last-beat flag and counts completed packets. It sits between the FIFO's read port (`r_en`, `data_out`, `empty`) and any valid/ready consumer.

## Interface
- `DATA_WIDTH`, default 8: word width; must match the FIFO.
- `PKT_LEN`, default 4: words per packet; must be ≥1.
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `en` input, 1: permits new FIFO reads. Buffered words still drain while `en`=0.
- `fifo_empty` input, 1: connects to the FIFO `empty` output.
- `fifo_data_out` input, DATA_WIDTH: connects to the FIFO `data_out` output.
- `fifo_r_en` output, 1: connects to the FIFO `r_en` input. Combinational.
- `m_valid` output, 1: stream word available.
- `m_ready` input, 1: consumer accepts the word.
- `m_data` output, DATA_WIDTH: stream word, taken from the buffer head.
- `m_last` output, 1: current word is the final beat of a packet.
- `pkt_count` output, 16: number of completed packets; wraps modulo 2^16.

## Operation
- FIFO read contract:
  - A read fires on any edge where `fifo_r_en`=1 and `fifo_empty`=0.
  - The FIFO `data_out` holds that word during the following cycle.
- `fifo_r_en` = `rst_n` & `en` & !`fifo_empty` & (`occ` + `inflight` − `pop` < 2).
  - `occ` is the buffer occupancy, 0..2.
  - `inflight` is a register, set to 1 for the cycle after a read fires.
  - `pop` = `m_valid` & `m_ready`.
- Capture: when `inflight`=1, `fifo_data_out` is written into the buffer tail at the end of that cycle.
  - Overflow is impossible by the credit rule.
- Output:
  - `m_valid` = (`occ`>0).
  - `m_data` = buffer head.
  - Words leave in FIFO order; there is no duplication and no loss.
- Same-cycle capture and pop: `occ` is unchanged, the head advances, and the captured word enters behind any remaining word.
- Hold rule: while `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` stay stable.
- Beat counter `beat` (0..PKT_LEN−1):
  - Increments on `pop`; wraps to 0 after PKT_LEN−1.
  - `m_last` = `m_valid` & (`beat`==PKT_LEN−1). With PKT_LEN=1, `m_last` = `m_valid`.
  - `pkt_count` increments on `pop` & `m_last`.
- `en` falling: no new reads are issued. An in-flight word is still captured, and all buffered words still drain. `beat` is preserved.
- Reset (asynchronous, at any time):
  - `occ`, `inflight`, `beat`, `pkt_count` and buffer contents go to 0.
  - Outputs: `m_valid`=0, `m_last`=0, `m_data`=0, `fifo_r_en`=0.
  - An in-flight word is discarded. The FIFO shares `rst_n` and is cleared in the same reset.

## Timing
- Latency: with the FIFO non-empty and the buffer empty, `fifo_r_en` is high in cycle 0, the FIFO presents the word in cycle 1, and `m_valid` is high in cycle 2.
- Throughput: one word per cycle sustained while `m_ready`=1 and the FIFO stays non-empty.
- Backpressure: with `m_ready` held low, at most 2 reads fire, then `fifo_r_en` stays 0.
- Empty: `fifo_r_en` is never 1 in a cycle where `fifo_empty`=1.
- Combinational paths:
  - `fifo_r_en` depends on `m_ready` and `fifo_empty`.
  - No path from `m_ready` to `m_valid` or `m_data`.

## Test plan
- Reset: hold `rst_n`=0 with `fifo_empty`=0, `en`=1 → `fifo_r_en`, `m_valid`, `m_last` are all 0, `m_data`=0, `pkt_count`=0.
- Streaming:
  - Stimulus: FIFO loaded with A1, B2, C3, D4, E5; `m_ready`=1; `en`=1; PKT_LEN=4.
  - Response: `fifo_r_en` goes high on the first cycle after `empty` falls. A1 appears 2 cycles later, then B2, C3, D4 on consecutive cycles. `m_last`=1 only on D4, and `pkt_count` becomes 1 after D4. E5 then appears with `m_last`=0.
- Backpressure:
  - Stimulus: FIFO holds A1, B2, C3; `m_ready`=0.
  - Response: exactly 2 reads fire. `m_data`=A1 stays stable. C3 remains in the FIFO (`empty`=0).
  - Raise `m_ready` → A1, B2, C3 are delivered in order, with C3 one cycle after B2 at the earliest possible point.
- Enable gating: drop `en` the cycle after the first read of A1, B2, C3 → A1 is delivered. No further reads fire while `en`=0. B2 and C3 remain in the FIFO until `en` returns.
- Empty guard: `fifo_empty`=1 throughout with `en`=1 and `m_ready`=1 → `fifo_r_en` and `m_valid` stay 0 for 20 cycles.
- Reset mid-packet:
  - Stimulus: assert `rst_n`=0 asynchronously while `m_valid`=1 and `beat`=2.
  - Response: `m_valid` drops without waiting for a clock edge, and `beat` is 0.
  - After release with D4..H8 loaded: `m_last` is on G7, the 4th word.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream through a 2-entry skid buffer,
// tagging every PKT_LEN-th word as the last beat and counting finished packets.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [15:0]           pkt_count
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [15:0]           pkt_q, pkt_d;

    logic       pop;
    logic [2:0] committed;
    logic       credit_ok;

    // Words already held or on their way must leave room for one more, counting
    // the slot freed by a pop in this same cycle.
    assign pop       = m_valid & m_ready;
    assign committed = {1'b0, occ_q} + {2'b00, inflight_q};
    assign credit_ok = committed < (3'd2 + {2'b00, pop});
    assign fifo_r_en = rst_n & en & ~fifo_empty & credit_ok;

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = buf0_q;
    assign m_last    = m_valid & (beat_q == LAST_BEAT);
    assign pkt_count = pkt_q;

    always_comb begin
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        occ_d      = occ_q;
        inflight_d = fifo_r_en & ~fifo_empty;

        // buf0 is always the head; a pop shifts buf1 forward, a capture lands behind
        // whatever remains after that shift.
        case ({inflight_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = fifo_data_out;
                end else begin
                    buf1_d = fifo_data_out;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = fifo_data_out;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data_out;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        beat_d = beat_q;
        pkt_d  = pkt_q;
        if (pop) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
            if (m_last) begin
                pkt_d = pkt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            beat_q     <= '0;
            pkt_q      <= 16'd0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            beat_q     <= beat_d;
            pkt_q      <= pkt_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a behavioural FIFO feeds the DUT and a queue-based
// scoreboard predicts stream order, timing, packet boundaries and read strobes.
module tb_fifo_stream_reader;

    localparam int DW      = 8;
    localparam int PKT_LEN = 4;

    logic          clk = 1'b0;
    logic          rstN, en, mReady;
    logic          fifoEmpty, fifoREn, mValid, mLast;
    logic [DW-1:0] fifoData, mData;
    logic [15:0]   pktCount;

    logic [DW-1:0] mem [256];
    int            wrPtr = 0;
    int            rdPtr = 0;

    logic [DW-1:0] wordQ[$];
    int            readCyc[$];
    int            beatsDone, cyc, readsFired;
    logic          holdPrev, prevLast;
    logic [DW-1:0] prevData, lastWordSeen;
    int            passCount = 0;
    int            failCount = 0;
    int            checkCount = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PKT_LEN)) dut (
        .clk           (clk),
        .rst_n         (rstN),
        .en            (en),
        .fifo_empty    (fifoEmpty),
        .fifo_data_out (fifoData),
        .fifo_r_en     (fifoREn),
        .m_valid       (mValid),
        .m_ready       (mReady),
        .m_data        (mData),
        .m_last        (mLast),
        .pkt_count     (pktCount)
    );

    // Behavioural FIFO: one-cycle read latency, cleared by the shared reset.
    assign fifoEmpty = (wrPtr == rdPtr);

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rdPtr    <= wrPtr;
            fifoData <= '0;
        end else if (fifoREn && !fifoEmpty) begin
            fifoData <= mem[rdPtr & 255];
            rdPtr    <= rdPtr + 1;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pushWord(input logic [DW-1:0] w);
        mem[wrPtr & 255] = w;
        wrPtr++;
        wordQ.push_back(w);
    endtask

    task automatic applyStimulus(input logic enV, input logic readyV);
        en     = enV;
        mReady = readyV;
    endtask

    task automatic resetModel();
        wordQ.delete();
        readCyc.delete();
        beatsDone = 0;
        holdPrev  = 1'b0;
    endtask

    // A word read in cycle c is presentable from cycle c+2; reads stay outstanding
    // until accepted, and at most two may be outstanding after this cycle's pop.
    task automatic checkCycle();
        logic expValid, expREn, fire, pop;
        int   pending;
        expValid = 1'b0;
        if (readCyc.size() > 0) expValid = (readCyc[0] <= cyc - 2);
        pending = readCyc.size();
        expREn  = rstN && en && !fifoEmpty && ((pending - int'(expValid && mReady)) < 2);
        checkOutput("mValid", mValid, expValid);
        checkOutput("fifoREn", fifoREn, expREn);
        if (mValid && wordQ.size() > 0) begin
            checkOutput("mData", mData, wordQ[0]);
            checkOutput("mLast", mLast, (beatsDone % PKT_LEN) == PKT_LEN - 1);
        end else if (!mValid) begin
            checkOutput("mLastIdle", mLast, 1'b0);
        end
        checkOutput("pktCount", pktCount, (beatsDone / PKT_LEN) % 65536);
        if (holdPrev) begin
            checkOutput("holdData", mData, prevData);
            checkOutput("holdLast", mLast, prevLast);
        end
        fire = fifoREn && !fifoEmpty;
        pop  = mValid && mReady;
        if (fire) begin
            readCyc.push_back(cyc);
            readsFired++;
        end
        if (pop) begin
            if (mLast) lastWordSeen = mData;
            if (readCyc.size() > 0) void'(readCyc.pop_front());
            if (wordQ.size() > 0) void'(wordQ.pop_front());
            beatsDone++;
        end
        holdPrev = mValid && !mReady;
        prevData = mData;
        prevLast = mLast;
        if (!rstN) resetModel();
        cyc++;
    endtask

    task automatic cycle();
        #1;
        checkCycle();
        @(negedge clk);
    endtask

    task automatic drain();
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 60 && (wordQ.size() > 0 || mValid); i++) cycle();
        checkOutput("drained", wordQ.size(), 0);
    endtask

    initial begin
        int   r0, b0, seen;
        logic found;
        logic [DW-1:0] words [5];
        rstN = 1'b0;
        applyStimulus(1'b1, 1'b1);
        resetModel();
        cyc = 0;
        readsFired = 0;
        lastWordSeen = '0;
        @(negedge clk);

        pushWord(8'h5A);
        #1;
        checkOutput("rstREn", fifoREn, 1'b0);
        checkOutput("rstValid", mValid, 1'b0);
        checkOutput("rstLast", mLast, 1'b0);
        checkOutput("rstData", mData, 8'h00);
        checkOutput("rstPkt", pktCount, 16'd0);
        @(negedge clk);
        resetModel();
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] streaming");
        words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        foreach (words[i]) pushWord(words[i]);
        #1;
        checkOutput("latREn0", fifoREn, 1'b1);
        cycle();
        checkOutput("latValid1", mValid, 1'b0);
        cycle();
        checkOutput("latValid2", mValid, 1'b1);
        checkOutput("latData2", mData, 8'hA1);
        repeat (8) cycle();
        checkOutput("streamPkt", pktCount, 16'd1);
        checkOutput("streamLastWord", lastWordSeen, 8'hD4);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 1'b0);
        pushWord(8'hA1); pushWord(8'hB2); pushWord(8'hC3);
        r0 = readsFired;
        repeat (8) cycle();
        checkOutput("bpReads", readsFired - r0, 2);
        checkOutput("bpFifoEmpty", fifoEmpty, 1'b0);
        checkOutput("bpHeadData", mData, 8'hA1);
        drain();

        $display("[TB] enable gating");
        pushWord(8'hA1); pushWord(8'hB2); pushWord(8'hC3);
        cycle();
        applyStimulus(1'b0, 1'b1);
        r0 = readsFired;
        b0 = beatsDone;
        repeat (10) cycle();
        checkOutput("enReads", readsFired - r0, 0);
        checkOutput("enDelivered", beatsDone - b0, 1);
        checkOutput("enFifoEmpty", fifoEmpty, 1'b0);
        drain();

        $display("[TB] empty guard");
        seen = 0;
        repeat (20) begin
            cycle();
            if (fifoREn || mValid) seen++;
        end
        checkOutput("emptyIdle", seen, 0);

        $display("[TB] random traffic");
        repeat (400) begin
            if ($urandom_range(0, 2) == 0 && wordQ.size() < 16) pushWord(8'($urandom));
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("[TB] reset mid-packet");
        for (int i = 0; i < 8; i++) pushWord(8'(8'h10 + i));
        applyStimulus(1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mValid && (beatsDone % PKT_LEN) == 2) found = 1'b1;
            else cycle();
        end
        checkOutput("midPktReached", found, 1'b1);
        mReady = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("asyncValid", mValid, 1'b0);
        checkOutput("asyncLast", mLast, 1'b0);
        checkOutput("asyncData", mData, 8'h00);
        checkOutput("asyncPkt", pktCount, 16'd0);
        checkOutput("asyncREn", fifoREn, 1'b0);
        resetModel();
        @(negedge clk);
        cycle();
        cycle();
        rstN = 1'b1;
        words = '{8'hD4, 8'hE5, 8'hF6, 8'h47, 8'h58};
        foreach (words[i]) pushWord(words[i]);
        applyStimulus(1'b1, 1'b1);
        lastWordSeen = '0;
        repeat (12) cycle();
        checkOutput("postRstLastWord", lastWordSeen, 8'h47);
        checkOutput("postRstPkt", pktCount, 16'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
